// File: rtl/regfile_mp_pkg.sv
// Shared types for the multi-ported register file and its clear engine.
package regfile_mp_pkg;

   typedef enum logic {
      CLR_IDLE  = 1'b0,
      CLR_SWEEP = 1'b1
   } clr_state_e;

endpackage

// File: rtl/regfile_mp_clear_fsm.sv
// Sequential clear engine: walks every register index once per clr_req, one per cycle.
module rf_clear_fsm
   import regfile_mp_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr_req,
   output logic                      clr_busy,
   output logic [REG_ADDR_WIDTH-1:0] clr_idx,
   output logic                      clr_we
);

   clr_state_e                state_q, state_d;
   logic [REG_ADDR_WIDTH-1:0] idx_q, idx_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= CLR_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         CLR_IDLE: begin
            if (clr_req) begin
               state_d = CLR_SWEEP;
               idx_d   = '0;
            end
         end
         CLR_SWEEP: begin
            // Increment wraps the index back to zero as the last entry is cleared.
            idx_d = idx_q + 1'b1;
            if (idx_q == '1) begin
               state_d = CLR_IDLE;
            end
         end
         default: begin
            state_d = CLR_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   assign clr_busy = (state_q == CLR_SWEEP);
   assign clr_we   = (state_q == CLR_SWEEP);
   assign clr_idx  = idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported integer register file with write->read bypass, pending scoreboard and sweep clear.
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int REGISTER_WIDTH = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int NUM_RD         = 2,
   parameter int NUM_WR         = 2,
   parameter int BYPASS         = 1,
   parameter int ZERO_REG       = 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic [NUM_RD*REG_ADDR_WIDTH-1:0]   rd_addr,
   output logic [NUM_RD*REGISTER_WIDTH-1:0]   rd_data,
   output logic [NUM_RD-1:0]                  rd_pend,
   input  logic [NUM_WR-1:0]                  wr_en,
   input  logic [NUM_WR*REG_ADDR_WIDTH-1:0]   wr_addr,
   input  logic [NUM_WR*REGISTER_WIDTH-1:0]   wr_data,
   input  logic                               busy_set,
   input  logic [REG_ADDR_WIDTH-1:0]          busy_addr,
   input  logic                               clr_req,
   output logic                               clr_busy
);

   localparam int AW       = REG_ADDR_WIDTH;
   localparam int RW       = REGISTER_WIDTH;
   localparam int RF_DEPTH = 2**AW;

   logic [RW-1:0]       rf_q [RF_DEPTH];
   logic [RW-1:0]       rf_d [RF_DEPTH];
   logic [RF_DEPTH-1:0] pend_q, pend_d;
   logic [NUM_WR-1:0]   wr_qual;
   logic                busy_qual;
   logic [AW-1:0]       clr_idx;
   logic                clr_we;

   rf_clear_fsm #(
      .REG_ADDR_WIDTH(AW)
   ) u_clear (
      .clk     (clk),
      .rst     (rst),
      .clr_req (clr_req),
      .clr_busy(clr_busy),
      .clr_idx (clr_idx),
      .clr_we  (clr_we)
   );

   always_comb begin
      wr_qual = '0;
      for (int unsigned j = 0; j < NUM_WR; j++) begin
         wr_qual[j] = start & wr_en[j] & ~clr_busy &
                      ~((ZERO_REG != 0) && (wr_addr[j*AW +: AW] == '0));
      end
      busy_qual = start & busy_set & ~clr_busy & ~((ZERO_REG != 0) && (busy_addr == '0));
   end

   // Ascending port order makes the youngest write win; busy_set applied last so issue beats writeback.
   always_comb begin
      rf_d   = rf_q;
      pend_d = pend_q;
      if (clr_we) begin
         rf_d[clr_idx]   = '0;
         pend_d[clr_idx] = 1'b0;
      end
      for (int unsigned j = 0; j < NUM_WR; j++) begin
         if (wr_qual[j]) begin
            rf_d[wr_addr[j*AW +: AW]]   = wr_data[j*RW +: RW];
            pend_d[wr_addr[j*AW +: AW]] = 1'b0;
         end
      end
      if (busy_qual) begin
         pend_d[busy_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < RF_DEPTH; i++) begin
            rf_q[i] <= '0;
         end
         pend_q <= '0;
      end else begin
         rf_q   <= rf_d;
         pend_q <= pend_d;
      end
   end

   always_comb begin
      rd_data = '0;
      rd_pend = '0;
      for (int unsigned k = 0; k < NUM_RD; k++) begin
         rd_data[k*RW +: RW] = rf_q[rd_addr[k*AW +: AW]];
         rd_pend[k]          = pend_q[rd_addr[k*AW +: AW]];
         if (BYPASS != 0) begin
            for (int unsigned j = 0; j < NUM_WR; j++) begin
               if (wr_qual[j] && (wr_addr[j*AW +: AW] == rd_addr[k*AW +: AW])) begin
                  rd_data[k*RW +: RW] = wr_data[j*RW +: RW];
                  rd_pend[k]          = 1'b0;
               end
            end
         end
         if ((ZERO_REG != 0) && (rd_addr[k*AW +: AW] == '0)) begin
            rd_data[k*RW +: RW] = '0;
            rd_pend[k]          = 1'b0;
         end
      end
   end

endmodule
